// File: rtl/jtpopeye_bckwr.sv
// CPU-side write initiator for the background nibble RAM: queues CPU writes and paces them onto the RAM write port.
// Optional CPU stall on a full queue instead of dropping writes: define JTPOPEYE_BCKWR_WAIT_EN.
module jtpopeye_bckwr #(
   parameter int AW   = 2,
   parameter int HOLD = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_cen,
   input  logic        bg_cs_n,
   input  logic        wr_n,
   input  logic [12:0] A,
   input  logic [7:0]  D,
   output logic        CSBW_n,
   output logic        DWRBK,
   output logic [12:0] AD,
   output logic [7:0]  DD,
   output logic        wait_n,
   output logic        full,
   output logic        ovf
);

   localparam int DEPTH = 1 << AW;
   localparam int CNTW  = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t          state_q;
   logic [CNTW-1:0] cnt_q;
   logic            csbw_q;
   logic            dwrbk_q;
   logic [12:0]     ad_q;
   logic [7:0]      dd_q;

   logic [20:0]     mem_q [DEPTH];
   logic [AW-1:0]   wrPtr_q;
   logic [AW-1:0]   rdPtr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     count_d;
   logic            wrLast_q;

   logic            capture;
   logic            pop;
   logic            push;
   logic            blocked;
   logic            wrLastEn;

   // A capture on a full queue is only refused when the engine is not freeing a slot this same clock.
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign capture = cpu_cen & ~bg_cs_n & ~wr_n & wrLast_q;
   assign pop     = (state_q == ST_IDLE) && (count_q != '0);
   assign blocked = capture & full & ~pop;
   assign push    = capture & ~blocked;

   assign CSBW_n  = csbw_q;
   assign DWRBK   = dwrbk_q;
   assign AD      = ad_q;
   assign DD      = dd_q;

`ifdef JTPOPEYE_BCKWR_WAIT_EN
   // Freezing the strobe history while stalled lets the same write fire once a slot frees up.
   assign wait_n   = ~(full & ~bg_cs_n & ~wr_n);
   assign wrLastEn = cpu_cen & ~blocked;
   assign ovf      = 1'b0;
`else
   logic ovf_q;

   assign wait_n   = 1'b1;
   assign wrLastEn = cpu_cen;
   assign ovf      = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (blocked) begin
         ovf_q <= 1'b1;
      end
   end
`endif

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         wrLast_q <= 1'b1;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
         if (wrLastEn) begin
            wrLast_q <= wr_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= {A, D};
      end
   end

   // CSBW_n stays low from SETUP through GAP so the controller finishes its read-modify-write before release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         csbw_q  <= 1'b1;
         dwrbk_q <= 1'b0;
         ad_q    <= '0;
         dd_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dwrbk_q <= 1'b0;
               if (pop) begin
                  {ad_q, dd_q} <= mem_q[rdPtr_q];
                  csbw_q       <= 1'b0;
                  state_q      <= ST_SETUP;
               end else begin
                  csbw_q <= 1'b1;
               end
            end
            ST_SETUP: begin
               dwrbk_q <= 1'b1;
               state_q <= ST_PULSE;
            end
            ST_PULSE: begin
               dwrbk_q <= 1'b0;
               cnt_q   <= CNTW'(HOLD - 1);
               state_q <= ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  state_q <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_GAP: begin
               csbw_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               csbw_q  <= 1'b1;
               dwrbk_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtpopeye_bckwr.sv
// Self-checking bench for jtpopeye_bckwr: directed vectors, multi-cycle corner sequences and random traffic
// checked every clock against a queue-and-timestamp reference model.
module tb_jtpopeye_bckwr;

   localparam int DEPTH = 4;
`ifdef JTPOPEYE_BCKWR_WAIT_EN
   localparam bit   waitEn       = 1'b1;
   localparam int   expDelivered = 8;
   localparam logic expOvfAfter  = 1'b0;
   localparam logic expSawWait   = 1'b1;
`else
   localparam bit   waitEn       = 1'b0;
   localparam int   expDelivered = 6;
   localparam logic expOvfAfter  = 1'b1;
   localparam logic expSawWait   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_cen = 1'b0;
   logic        bg_cs_n = 1'b1;
   logic        wr_n = 1'b1;
   logic [12:0] A = '0;
   logic [7:0]  D = '0;
   logic        CSBW_n;
   logic        DWRBK;
   logic [12:0] AD;
   logic [7:0]  DD;
   logic        wait_n;
   logic        full;
   logic        ovf;

   jtpopeye_bckwr dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cpu_cen (cpu_cen),
      .bg_cs_n (bg_cs_n),
      .wr_n    (wr_n),
      .A       (A),
      .D       (D),
      .CSBW_n  (CSBW_n),
      .DWRBK   (DWRBK),
      .AD      (AD),
      .DD      (DD),
      .wait_n  (wait_n),
      .full    (full),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model: a queue of pending writes plus the cycle of the last pop; each write owns
   // seven clocks starting at its pop, with CSBW_n low for offsets 1..6 and DWRBK high at offset 2.
   int          cyc = 0;
   int          popCyc = -100;
   logic [20:0] qM[$];
   logic        wrLastM = 1'b1;
   logic        ovfM = 1'b0;
   logic [12:0] adM = '0;
   logic [7:0]  ddM = '0;

   int          pulseCount;
   logic [12:0] pulseAd[$];
   logic [7:0]  pulseDd[$];
   int          pulseCyc[$];
   int          pulseLow[$];
   int          lowCount;
   int          adUnstable;
   logic [12:0] firstAd;
   logic [7:0]  firstDd;
   logic        sawWait;
   logic        sawFull;

   typedef struct {
      logic [12:0] a;
      logic [7:0]  d;
      logic [12:0] expAd;
      logic [7:0]  expDd;
   } vec_t;

   vec_t vecs[5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      qM.delete();
      popCyc  = -100;
      wrLastM = 1'b1;
      ovfM    = 1'b0;
      adM     = '0;
      ddM     = '0;
   endtask

   task automatic modelStep(input logic cen, input logic bg, input logic wr, input logic [12:0] a, input logic [7:0] d);
      logic doPop;
      logic cap;
      logic blk;
      doPop = (cyc >= popCyc + 7) && (qM.size() > 0);
      cap   = cen && !bg && !wr && wrLastM;
      blk   = cap && (qM.size() == DEPTH) && !doPop;
      if (doPop) begin
         {adM, ddM} = qM.pop_front();
         popCyc = cyc;
      end
      if (cap && !blk) qM.push_back({a, d});
      if (blk && !waitEn) ovfM = 1'b1;
      if (cen && !(blk && waitEn)) wrLastM = wr;
      cyc++;
   endtask

   task automatic clearLog();
      pulseCount = 0;
      pulseAd.delete();
      pulseDd.delete();
      pulseCyc.delete();
      pulseLow.delete();
      lowCount   = 0;
      adUnstable = 0;
      sawWait    = 1'b0;
      sawFull    = 1'b0;
   endtask

   // One clock: compare the settled outputs against the model, log pulses, then drive the next inputs.
   task automatic applyStimulus(input logic cen, input logic bg, input logic wr, input logic [12:0] a, input logic [7:0] d);
      int   phase;
      logic expWait;
      @(negedge clk);
      phase   = cyc - popCyc;
      expWait = waitEn ? !((qM.size() == DEPTH) && !bg_cs_n && !wr_n) : 1'b1;
      checkOutput("CSBW_n", CSBW_n, (phase >= 1 && phase <= 6) ? 1'b0 : 1'b1);
      checkOutput("DWRBK", DWRBK, (phase == 2) ? 1'b1 : 1'b0);
      checkOutput("AD", AD, adM);
      checkOutput("DD", DD, ddM);
      checkOutput("full", full, (qM.size() == DEPTH) ? 1'b1 : 1'b0);
      checkOutput("ovf", ovf, ovfM);
      checkOutput("wait_n", wait_n, expWait);
      if (CSBW_n === 1'b0) begin
         lowCount++;
         if (lowCount == 1) begin
            firstAd = AD;
            firstDd = DD;
         end else if (AD !== firstAd || DD !== firstDd) begin
            adUnstable++;
         end
      end
      if (DWRBK === 1'b1) begin
         pulseCount++;
         pulseAd.push_back(AD);
         pulseDd.push_back(DD);
         pulseCyc.push_back(cyc);
         pulseLow.push_back(lowCount);
      end
      if (wait_n === 1'b0) sawWait = 1'b1;
      if (full === 1'b1) sawFull = 1'b1;
      cpu_cen = cen;
      bg_cs_n = bg;
      wr_n    = wr;
      A       = a;
      D       = d;
      modelStep(cen, bg, wr, a, d);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 13'h0, 8'h0);
   endtask

   // CPU write: strobe low, held while the design requests wait, then released.
   task automatic cpuWrite(input logic [12:0] a, input logic [7:0] d);
      int n;
      applyStimulus(1'b1, 1'b0, 1'b0, a, d);
      n = 0;
      #1;
      while (wait_n === 1'b0 && n < 40) begin
         applyStimulus(1'b1, 1'b0, 1'b0, a, d);
         n++;
         #1;
      end
      checkOutput("waitBound", 32'(n >= 40), 0);
      applyStimulus(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".CSBW_n"}, CSBW_n, 1'b1);
      checkOutput({tag, ".DWRBK"}, DWRBK, 1'b0);
      checkOutput({tag, ".AD"}, AD, 13'h0);
      checkOutput({tag, ".DD"}, DD, 8'h0);
      checkOutput({tag, ".wait_n"}, wait_n, 1'b1);
      checkOutput({tag, ".full"}, full, 1'b0);
      checkOutput({tag, ".ovf"}, ovf, 1'b0);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      cpu_cen = 1'b0;
      bg_cs_n = 1'b1;
      wr_n    = 1'b1;
      #2 rst_n = 1'b0;
      #1 checkResetValues(tag);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          guard;
      int          nW;
      logic [12:0] gotAd;
      logic [7:0]  gotDd;
      int          gotLow;

      vecs[0] = '{13'h0123, 8'h5A, 13'h0123, 8'h5A};
      vecs[1] = '{13'h1FFF, 8'hFF, 13'h1FFF, 8'hFF};
      vecs[2] = '{13'h1000, 8'h0F, 13'h1000, 8'h0F};
      vecs[3] = '{13'h0ABC, 8'hC3, 13'h0ABC, 8'hC3};
      vecs[4] = '{13'h0000, 8'h00, 13'h0000, 8'h00};

      #3 rst_n = 1'b0;
      #1 checkResetValues("reset");
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      $display("[TB] directed single writes");
      for (int i = 0; i < 5; i++) begin
         clearLog();
         cpuWrite(vecs[i].a, vecs[i].d);
         idle(10);
         gotAd  = 'x;
         gotDd  = 'x;
         gotLow = -1;
         if (pulseAd.size() > 0) begin
            gotAd  = pulseAd[0];
            gotDd  = pulseDd[0];
            gotLow = pulseLow[0];
         end
         checkOutput("vecLowClocks", lowCount, 6);
         checkOutput("vecPulses", pulseCount, 1);
         checkOutput("vecPulseSlot", gotLow, 2);
         checkOutput("vecAD", gotAd, vecs[i].expAd);
         checkOutput("vecDD", gotDd, vecs[i].expDd);
         checkOutput("vecStable", adUnstable, 0);
      end

      $display("[TB] strobe held low for ten ticks");
      clearLog();
      applyStimulus(1'b1, 1'b1, 1'b1, 13'h0, 8'h0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 13'h0456, 8'h21);
         applyStimulus(1'b0, 1'b0, 1'b0, 13'h0456, 8'h21);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 13'h0456, 8'h21);
      idle(15);
      checkOutput("heldLowPulses", pulseCount, 1);

      $display("[TB] burst of four");
      clearLog();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 13'h1000 + 13'(i), 8'h30 + 8'(i));
         applyStimulus(1'b0, 1'b0, 1'b0, 13'h1000 + 13'(i), 8'h30 + 8'(i));
         applyStimulus(1'b1, 1'b0, 1'b1, 13'h1000 + 13'(i), 8'h30 + 8'(i));
         applyStimulus(1'b0, 1'b0, 1'b1, 13'h1000 + 13'(i), 8'h30 + 8'(i));
      end
      idle(30);
      checkOutput("burstPulses", pulseCount, 4);
      checkOutput("burstFull", sawFull, 1'b0);
      for (int k = 0; k < pulseAd.size(); k++) checkOutput("burstOrder", pulseAd[k], 13'h1000 + k);
      for (int k = 1; k < pulseCyc.size(); k++) checkOutput("burstGap", pulseCyc[k] - pulseCyc[k-1], 7);

      $display("[TB] overflow burst");
      clearLog();
      for (int i = 0; i < 8; i++) cpuWrite(13'h0200 + 13'(i), 8'hA0 + 8'(i));
      idle(70);
      checkOutput("ovfDelivered", pulseCount, expDelivered);
      checkOutput("ovfFlag", ovf, expOvfAfter);
      checkOutput("ovfWaitSeen", sawWait, expSawWait);
      for (int k = 0; k < pulseAd.size(); k++) checkOutput("ovfOrder", pulseAd[k], 13'h0200 + k);

      $display("[TB] push and pop together while full");
      doReset("reset2");
      clearLog();
      nW = 0;
      guard = 0;
      while (qM.size() < DEPTH && guard < 20) begin
         cpuWrite(13'h0300 + 13'(nW), 8'h10 + 8'(nW));
         nW++;
         guard++;
      end
      checkOutput("fillBound", 32'(guard >= 20), 0);
      guard = 0;
      while (!(cyc >= popCyc + 7 && qM.size() > 0) && guard < 20) begin
         idle(1);
         guard++;
      end
      checkOutput("popBound", 32'(guard >= 20), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 13'h0300 + 13'(nW), 8'h10 + 8'(nW));
      nW++;
      #1;
      checkOutput("pushPopFull", full, 1'b1);
      checkOutput("pushPopOvf", ovf, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 13'h0, 8'h0);
      idle(50);
      checkOutput("pushPopDelivered", pulseCount, nW);

      $display("[TB] reset during hold");
      clearLog();
      for (int i = 0; i < 3; i++) cpuWrite(13'h0700 + 13'(i), 8'h55);
      guard = 0;
      while (cyc - popCyc != 4 && guard < 30) begin
         idle(1);
         guard++;
      end
      checkOutput("holdBound", 32'(guard >= 30), 0);
      #1 checkOutput("holdCsbw", CSBW_n, 1'b0);
      doReset("midReset");
      clearLog();
      idle(20);
      checkOutput("postResetPulses", pulseCount, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       13'($urandom), 8'($urandom));
      end
      doReset("reset3");
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
                       13'($urandom), 8'($urandom));
      end
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtpopeye_bckwr.md
Name: jtpopeye_bckwr

Overview:
CPU-side write initiator for the background nibble RAM.
- Captures CPU background writes on cpu_cen, queues them in a small FIFO, and replays each one on the background RAM controller's write port as CSBW_n/AD/DD plus a one-clock DWRBK pulse.
- Paces the writes so the controller's three-step read-modify-write sequence always completes before the next pulse.
- Sits between the Z80 bus decode and the background RAM block.

Parameters:
- AW, 2, log2 of FIFO depth (4 entries).
- HOLD, 3, clk cycles CSBW_n/AD/DD stay valid after the DWRBK pulse; minimum 3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_cen  in  1  CPU clock enable
- bg_cs_n  in  1  background write region selected, active-low
- wr_n  in  1  CPU write strobe, active-low
- A  in  13  CPU address; bit 12 is the nibble select, 11:0 the RAM address
- D  in  8  CPU data
- CSBW_n  out  1  write-port select to the RAM controller, active-low
- DWRBK  out  1  write pulse; the controller acts on its rising edge
- AD  out  13  write address
- DD  out  8  write data; the controller uses DD[3:0]
- wait_n  out  1  CPU wait request, active-low
- full  out  1  FIFO full
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset values: CSBW_n=1, DWRBK=0, AD=0, DD=0, wait_n=1, full=0, ovf=0. FIFO pointers and count are cleared; the engine goes to IDLE.
- A reset asserted mid-write aborts immediately: CSBW_n=1, DWRBK=0, and queued entries are lost.
- Capture:
  - wr_last updates only when cpu_cen=1.
  - A push occurs on a clk where cpu_cen=1, bg_cs_n=0, wr_n=0 and wr_last=1.
  - Exactly one push per CPU write, even if wr_n stays low for many cpu_cen ticks.
  - Each entry is {A,D}, 21 bits.
- FIFO:
  - Depth is 2^AW.
  - Count width is AW+1.
  - Pointers wrap modulo depth.
  - full = (count == 2^AW).
- Simultaneous push and pop on one clk: both happen and count is unchanged. This is legal even when full, because the pop frees the slot in the same cycle.
- Push when full with no pop in that cycle: behaviour depends on the optional feature.
- Engine states:
  - IDLE: if the FIFO is not empty, pop the head into AD/DD, drive CSBW_n=0, go to SETUP. Otherwise CSBW_n=1 and DWRBK=0.
  - SETUP: one clk with AD/DD stable and CSBW_n=0. Go to PULSE.
  - PULSE: DWRBK=1 for exactly one clk. Go to HOLD with cnt=HOLD-1.
  - HOLD: DWRBK=0 and CSBW_n=0 with AD/DD unchanged. Decrement cnt; at cnt=0 go to GAP.
  - GAP: CSBW_n=1 for one clk so the controller sees DWRBK low and resumes video reads. Go to IDLE.
- Per-write budget: 1 (IDLE) + 1 + 1 + HOLD + 1 = 7 clk for HOLD=3.
- Latency: the first DWRBK rise occurs 2 clk after the pop.
- AD and DD change only in IDLE on a pop.
- DWRBK never rises while CSBW_n=1.
- AD is passed unaltered, so the controller selects the low nibble when A[12]=1 and the high nibble when A[12]=0.
- Outside SETUP..HOLD, AD and DD keep their last values.

Optional Feature:
- Macro: JTPOPEYE_BCKWR_WAIT_EN.
- Defined:
  - wait_n = 0 while full=1 and a write is pending (bg_cs_n=0, wr_n=0).
  - The push is held off rather than dropped: wr_last is not updated while stalled, so the capture fires once space frees.
  - ovf is tied to 0.
- Undefined:
  - wait_n is tied to 1.
  - A push while full with no pop is discarded and sets ovf=1 until reset.

Test Plan:
- Single write A=0x0123, D=0x5A, HOLD=3 -> CSBW_n low 6 clk; AD=0x0123 and DD=0x5A for all 6; DWRBK high exactly 1 clk, on the 2nd clk after CSBW_n falls; CSBW_n high 1 clk before IDLE.
- wr_n held low for 10 cpu_cen ticks with bg_cs_n=0 -> exactly one DWRBK pulse.
- Burst of 4 writes (A=0x1000..0x1003) on consecutive cpu_cen ticks, cpu_cen every 4 clk -> 4 DWRBK pulses in order, each 7 clk apart; full never asserted.
- 6 writes on back-to-back clk with cpu_cen=1, drain blocked for the first 4 -> macro undefined: 4 delivered, 5th and 6th dropped, ovf=1. Macro defined: wait_n=0 from the 5th write until a pop, all 6 delivered in order.
- Push and pop in the same clk with count=4 -> count stays 4, full stays 1, ovf stays 0.
- rst_n pulsed low during HOLD -> CSBW_n=1 and DWRBK=0 asynchronously; after release, no pulse until a new write arrives.
